// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-level round-robin arbiter for the single write
// port of the CDC FIFO. One requester holds the grant for a whole packet
// (delimited by req_last, or cut at MAX_PKT_BEATS) and its beats are passed
// straight through to the FIFO write port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/last  per-requester beat valid / last beat of packet
//   req_data        requester i data at [i*DATA_LEN +: DATA_LEN]
//   req_ready       per-requester beat accepted (combinational)
//   fifo_full       FIFO cannot accept a write this cycle
//   fifo_write_en   FIFO write strobe (combinational)
//   fifo_data_in    FIFO write data (combinational, zero outside XFER)
//   grant_id        currently / last granted requester
//   busy            high while a grant is active
//   pkt_done        one-cycle pulse the cycle after a grant is released
//   overrun_err     sticky: a packet exceeded MAX_PKT_BEATS
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned DATA_LEN      = 16,
  parameter int unsigned MAX_PKT_BEATS = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_LEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_LEN-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          overrun_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_PKT_BEATS + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_rr_ptr;
  logic [CW-1:0] r_beat_cnt;
  logic          r_pkt_done;
  logic          r_overrun;

  logic [0:0]    w_state_nxt;
  logic [GW-1:0] w_grant_nxt;
  logic [GW-1:0] w_rr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_done_nxt;
  logic          w_ovr_nxt;

  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;
  logic          w_xfer_ready;
  logic          w_accept;
  logic          w_last_beat;
  logic          w_cnt_max;

  // Round-robin pick: first valid requester after r_rr_ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Beat handshake for the granted requester.
  always_comb begin
    w_xfer_ready  = (r_state == XFER) && !fifo_full;
    w_accept      = w_xfer_ready && req_valid[r_grant];
    w_last_beat   = req_last[r_grant];
    w_cnt_max     = (r_beat_cnt == CW'(MAX_PKT_BEATS - 1));
    req_ready     = w_xfer_ready ? (NUM_REQ'(1) << r_grant) : '0;
    fifo_write_en = w_accept;
    fifo_data_in  = (r_state == XFER) ?
                    req_data[int'(r_grant)*int'(DATA_LEN) +: DATA_LEN] : '0;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_beat_cnt;
    w_done_nxt  = 1'b0;
    w_ovr_nxt   = r_overrun;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_accept) begin
          if (w_last_beat || w_cnt_max) begin
            // Grant released; an overrun cut leaves the tail to re-arbitrate.
            w_state_nxt = IDLE;
            w_rr_nxt    = r_grant;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            if (!w_last_beat) begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
      r_pkt_done <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_pkt_done <= w_done_nxt;
      r_overrun  <= w_ovr_nxt;
    end
  end

  assign grant_id    = r_grant;
  assign busy        = (r_state == XFER);
  assign pkt_done    = r_pkt_done;
  assign overrun_err = r_overrun;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed bench for fifo_write_arbiter (2 requesters,
// 16-bit data, MAX_PKT_BEATS=8). Requesters are simple beat sources; the
// written beats are logged and compared with hand-derived expectations.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [15:0] fifo_data_in;
  logic [0:0]  grant_id;
  logic        busy;
  logic        pkt_done;
  logic        overrun_err;

  fifo_write_arbiter #(
    .NUM_REQ      (2),
    .DATA_LEN     (16),
    .MAX_PKT_BEATS(8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write_en(fifo_write_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .overrun_err  (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Beat sources: beats left, beat index, packet length, data base.
  int          s_left[2];
  int          s_beat[2];
  int          s_plen[2];
  logic [15:0] s_base[2];

  // Sampled outputs of the most recent cycle.
  logic [1:0]  sm_ready;
  logic        sm_we;
  logic [15:0] sm_data;
  logic [0:0]  sm_grant;
  logic        sm_busy;
  logic        sm_done;
  logic        sm_ovr;

  logic [15:0] log_d[$];
  logic [0:0]  log_g[$];
  int          seg_q[$];
  int          cur_seg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive sources, sample at the falling edge, log writes,
  // advance sources that were accepted, then move past the next rising edge.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]         = (s_left[i] > 0);
      req_data[i*16 +: 16] = s_base[i] + 16'(s_beat[i]);
      req_last[i]          = (((s_beat[i] + 1) % s_plen[i]) == 0);
    end
    #4;
    sm_ready = req_ready;
    sm_we    = fifo_write_en;
    sm_data  = fifo_data_in;
    sm_grant = grant_id;
    sm_busy  = busy;
    sm_done  = pkt_done;
    sm_ovr   = overrun_err;
    if (sm_done === 1'b1) begin
      seg_q.push_back(cur_seg);
      cur_seg = 0;
    end
    if (sm_we === 1'b1) begin
      log_d.push_back(sm_data);
      log_g.push_back(sm_grant);
      cur_seg++;
    end
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && (sm_ready[i] === 1'b1)) begin
        s_beat[i]++;
        s_left[i]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 2; i++) begin
      s_left[i] = 0;
      s_beat[i] = 0;
      s_plen[i] = 1;
      s_base[i] = 16'h0000;
    end
  endtask

  task automatic clear_log();
    log_d.delete();
    log_g.delete();
    seg_q.delete();
    cur_seg = 0;
  endtask

  task automatic do_reset();
    clear_src();
    fifo_full = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic load_src(input int i, input int left, input int plen, input logic [15:0] base);
    s_left[i] = left;
    s_beat[i] = 0;
    s_plen[i] = plen;
    s_base[i] = base;
  endtask

  logic [15:0] we_hist;
  int          guard;
  int          n0;
  logic [15:0] exp_d;

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    clear_src();
    clear_log();
    @(posedge clk);
    #1;

    // 1: single 4-beat packet from requester 0, reset values first.
    do_reset();
    load_src(0, 4, 4, 16'h0001);
    tick();
    chk("rst_ready", 32'(sm_ready), 32'h0);
    chk("rst_we",    32'(sm_we),    32'h0);
    chk("rst_data",  32'(sm_data),  32'h0);
    chk("rst_grant", 32'(sm_grant), 32'h0);
    chk("rst_busy",  32'(sm_busy),  32'h0);
    chk("rst_done",  32'(sm_done),  32'h0);
    chk("rst_ovr",   32'(sm_ovr),   32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_we",    32'(sm_we),    32'h1);
      chk("t1_data",  32'(sm_data),  32'(k + 1));
      chk("t1_ready", 32'(sm_ready), 32'h1);
      chk("t1_busy",  32'(sm_busy),  32'h1);
    end
    tick();
    chk("t1_done",      32'(sm_done), 32'h1);
    chk("t1_idle_busy", 32'(sm_busy), 32'h0);
    chk("t1_idle_we",   32'(sm_we),   32'h0);
    tick();
    chk("t1_done_pulse", 32'(sm_done), 32'h0);
    chk("t1_nseg",       32'(seg_q.size()), 32'd1);
    chk("t1_nwr",        32'(log_d.size()), 32'd4);

    // 2: both requesters, two 3-beat packets each; grants alternate 0,1,0,1.
    do_reset();
    load_src(0, 6, 3, 16'h0A00);
    load_src(1, 6, 3, 16'h0B00);
    we_hist = '0;
    for (int c = 0; c < 16; c++) begin
      tick();
      we_hist[c] = sm_we;
    end
    chk("t2_we_pattern", 32'(we_hist), 32'h0000EEEE);
    chk("t2_nwr", 32'(log_d.size()), 32'd12);
    if (log_d.size() == 12) begin
      for (int p = 0; p < 4; p++) begin
        chk("t2_grant", 32'(log_g[3*p]), 32'(p % 2));
        for (int j = 0; j < 3; j++) begin
          exp_d = ((p % 2) == 1 ? 16'h0B00 : 16'h0A00) + 16'((p / 2) * 3 + j);
          chk("t2_data", 32'(log_d[3*p + j]), 32'(exp_d));
        end
      end
    end

    // 3: fifo_full for 5 cycles mid-packet; nothing lost or duplicated.
    do_reset();
    load_src(0, 6, 6, 16'h0011);
    tick();
    tick();
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_full_ready", 32'(sm_ready), 32'h0);
      chk("t3_full_we",    32'(sm_we),    32'h0);
      chk("t3_full_busy",  32'(sm_busy),  32'h1);
    end
    fifo_full = 1'b0;
    guard = 0;
    while (s_left[0] > 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("t3_timeout", 32'(s_left[0]), 32'h0);
    tick();
    tick();
    chk("t3_nwr",  32'(log_d.size()), 32'd6);
    chk("t3_nseg", 32'(seg_q.size()), 32'd1);
    chk("t3_ovr",  32'(sm_ovr),       32'h0);
    if (log_d.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("t3_data", 32'(log_d[k]), 32'(16'h0011 + 16'(k)));
    end

    // 4: 10-beat packet with an 8-beat limit: cut at 8, tail of 2 re-granted.
    do_reset();
    load_src(1, 10, 10, 16'h2001);
    guard = 0;
    while (s_left[1] > 0 && guard < 40) begin
      tick();
      if (log_d.size() < 8) chk("t4_ovr_early", 32'(sm_ovr), 32'h0);
      guard++;
    end
    chk("t4_timeout", 32'(s_left[1]), 32'h0);
    tick();
    tick();
    tick();
    chk("t4_ovr",  32'(sm_ovr),       32'h1);
    chk("t4_nwr",  32'(log_d.size()), 32'd10);
    chk("t4_nseg", 32'(seg_q.size()), 32'd2);
    if (seg_q.size() == 2) begin
      chk("t4_seg0", 32'(seg_q[0]), 32'd8);
      chk("t4_seg1", 32'(seg_q[1]), 32'd2);
    end
    if (log_d.size() == 10) begin
      for (int k = 0; k < 10; k++) begin
        chk("t4_data",  32'(log_d[k]), 32'(16'h2001 + 16'(k)));
        chk("t4_grant", 32'(log_g[k]), 32'h1);
      end
    end

    // 5: reset on the 3rd beat of a 6-beat packet; overrun also cleared.
    clear_log();
    load_src(0, 6, 6, 16'h0051);
    guard = 0;
    while (log_d.size() < 2 && guard < 20) begin
      tick();
      guard++;
    end
    chk("t5_timeout", 32'(log_d.size()), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_src();
    tick();
    chk("t5_ready", 32'(sm_ready), 32'h0);
    chk("t5_we",    32'(sm_we),    32'h0);
    chk("t5_data",  32'(sm_data),  32'h0);
    chk("t5_grant", 32'(sm_grant), 32'h0);
    chk("t5_busy",  32'(sm_busy),  32'h0);
    chk("t5_done",  32'(sm_done),  32'h0);
    chk("t5_ovr",   32'(sm_ovr),   32'h0);
    n0 = log_d.size();
    for (int c = 0; c < 5; c++) tick();
    chk("t5_no_writes", 32'(log_d.size() - n0), 32'd0);
    load_src(1, 1, 1, 16'h0077);
    tick();
    tick();
    tick();
    chk("t5_new_nwr", 32'(log_d.size() - n0), 32'd1);
    if (log_d.size() == n0 + 1) chk("t5_new_data", 32'(log_d[n0]), 32'h0077);

    // 6: single-beat packets from both requesters under random fifo_full.
    do_reset();
    load_src(0, 8, 1, 16'h3000);
    load_src(1, 8, 1, 16'h4000);
    guard = 0;
    while ((s_left[0] > 0 || s_left[1] > 0) && guard < 300) begin
      fifo_full = ($urandom_range(0, 2) == 0);
      tick();
      guard++;
    end
    fifo_full = 1'b0;
    chk("t6_timeout", 32'(s_left[0] + s_left[1]), 32'h0);
    tick();
    tick();
    chk("t6_nwr",  32'(log_d.size()), 32'd16);
    chk("t6_nseg", 32'(seg_q.size()), 32'd16);
    if (log_d.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        exp_d = ((k % 2) == 1 ? 16'h4000 : 16'h3000) + 16'(k / 2);
        chk("t6_data", 32'(log_d[k]), 32'(exp_d));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
